alu_result_stage: RTL and testbench

Registered output stage of the 32-bit ALU. It captures the 32 per-bit 4:1 mux results and the MSB carry signals for each operation, derives the N/Z/C/V flags, and buffers result and flags in a 2-entry FIFO behind a valid/ready handshake to the register-file writeback. It also keeps a saturating operation counter and a sticky overflow flag for debug.

---
 rtl/alu_result_stage.sv | 69 ++++++
 tb/tb_alu_result_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU result/flag capture into a 2-entry valid/ready FIFO with a saturating op counter and a sticky overflow flag.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result_in,
  input  logic [1:0]       sel,
  input  logic             carry_out,
  input  logic             carry_msb_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic [3:0]       flags_out,
  output logic [CNT_W-1:0] op_count,
  output logic             ovf_sticky,
  input  logic             clr_stats
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [3:0]       mem_f [DEPTH];
  logic             wptr, rptr;
  logic [1:0]       count, count_nxt;
  logic             push, pop;
  logic [3:0]       flags;
  always_comb begin
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    flags     = {result_in[WIDTH-1], result_in == '0, sel[1] & carry_out, sel[1] & (carry_out ^ carry_msb_in)};
    count_nxt = (push & ~pop) ? count + 2'd1 : (pop & ~push) ? count - 2'd1 : count;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      mem_r[0]   <= '0;
      mem_r[1]   <= '0;
      mem_f[0]   <= '0;
      mem_f[1]   <= '0;
      op_count   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      count     <= count_nxt;
      in_ready  <= count_nxt != 2'd2;
      out_valid <= count_nxt != 2'd0;
      if (push) begin
        mem_r[wptr] <= result_in;
        mem_f[wptr] <= flags;
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (clr_stats) begin
        op_count   <= '0;
        ovf_sticky <= 1'b0;
      end else if (push) begin
        op_count   <= (op_count == '1) ? op_count : op_count + 1'b1;
        ovf_sticky <= ovf_sticky | flags[0];
      end
    end
  end
  assign result_out = mem_r[rptr];
  assign flags_out  = mem_f[rptr];
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, clr_stats = 0;
  logic        carry_out = 0, carry_msb_in = 0;
  logic [1:0]  sel = 0;
  logic [31:0] result_in = 0;
  logic        in_ready, out_valid, ovf_sticky;
  logic [31:0] result_out;
  logic [3:0]  flags_out;
  logic [15:0] op_count;
  int          n_cmp = 0, n_bad = 0;
  logic [35:0] q[$];
  int          m_cnt = 0;
  bit          m_ovf = 0;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .result_in(result_in), .sel(sel), .carry_out(carry_out), .carry_msb_in(carry_msb_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out), .flags_out(flags_out),
    .op_count(op_count), .ovf_sticky(ovf_sticky), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
    chk("op_count", 32'(op_count), m_cnt);
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
    if (q.size() != 0) begin
      chk("result_out", result_out, q[0][35:4]);
      chk("flags_out", 32'(flags_out), 32'(q[0][3:0]));
    end
  endtask

  task automatic step(bit v, bit [1:0] s, bit [31:0] r, bit co, bit cm, bit ordy, bit clr);
    bit do_push, do_pop, arith, vf;
    bit [3:0] f;
    in_valid = v; sel = s; result_in = r; carry_out = co; carry_msb_in = cm;
    out_ready = ordy; clr_stats = clr;
    @(posedge clk);
    do_push = v && q.size() < 2;
    do_pop  = ordy && q.size() > 0;
    arith   = (s == 2) || (s == 3);
    vf      = arith && (co != cm);
    f       = {r[31], r == 0, arith && co, vf};
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back({r, f});
    if (clr) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (do_push) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_ovf = m_ovf | vf;
    end
    #1 check_all();
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_result", result_out, 0);
    chk("rst_flags", 32'(flags_out), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_ovf", 32'(ovf_sticky), 0);
    @(negedge clk);
    rst_n = 1;

    step(1, 2'b10, 32'h0000_0000, 1, 1, 1, 0);
    chk("flags_add_zero", 32'(flags_out), 32'h6);
    step(1, 2'b11, 32'h8000_0000, 0, 1, 1, 0);
    chk("flags_sub_neg_ovf", 32'(flags_out), 32'h9);
    chk("sticky_set", 32'(ovf_sticky), 1);
    step(1, 2'b00, 32'h8000_0000, 1, 1, 1, 0);
    chk("flags_and_neg", 32'(flags_out), 32'h8);
    step(0, 0, 0, 0, 0, 1, 0);

    step(1, 2'b01, 32'hA, 0, 0, 0, 0);
    step(1, 2'b01, 32'hB, 0, 0, 0, 0);
    chk("full_in_ready", 32'(in_ready), 0);
    step(1, 2'b01, 32'hC, 0, 0, 0, 0);
    chk("full_op_count", 32'(op_count), 5);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("pop_b", result_out, 32'hB);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("drained", 32'(out_valid), 0);

    step(1, 2'b10, 32'h5, 1, 0, 1, 1);
    chk("clr_op_count", 32'(op_count), 0);
    chk("clr_ovf", 32'(ovf_sticky), 0);
    step(0, 0, 0, 0, 0, 1, 0);

    for (int i = 1; i <= 10; i++) begin
      step(1, 2'b10, 32'(i), 0, 0, 1, 0);
      chk("stream_data", result_out, 32'(i));
    end
    chk("stream_count", 32'(op_count), 10);
    step(0, 0, 0, 0, 0, 1, 0);

    step(1, 2'b00, 32'h11, 0, 0, 0, 0);
    step(1, 2'b00, 32'h22, 0, 0, 1, 0);
    chk("pushpop_head", result_out, 32'h22);
    step(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 300; i++)
      step($urandom % 2 == 0, 2'($urandom), $urandom, 1'($urandom), 1'($urandom),
           $urandom % 4 != 0, $urandom % 20 == 0);

    step(1, 2'b00, 32'h1, 0, 0, 0, 0);
    step(1, 2'b00, 32'h2, 0, 0, 0, 0);
    #3 rst_n = 0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_in_ready", 32'(in_ready), 1);
    chk("async_op_count", 32'(op_count), 0);
    chk("async_ovf", 32'(ovf_sticky), 0);
    q.delete();
    m_cnt = 0;
    m_ovf = 0;
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("no_stale", 32'(out_valid), 0);

    for (int i = 0; i < 65535; i++) step(1, 2'b00, 32'(i), 0, 0, 1, 0);
    chk("sat_reach", 32'(op_count), 32'hFFFF);
    step(1, 2'b10, 32'h7, 1, 0, 1, 0);
    chk("sat_hold", 32'(op_count), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
